// File: rtl/bitstream_sched.sv
// bitstream_sched: picks which bitstream producer (SPI flash controller or SPI
// receiver) feeds the configuration engine. It issues cold-boot and warmboot
// start pulses to the flash controller and queues one warmboot request
// (last wins) while a load is in flight. A watchdog aborts a flash load that
// stops delivering words and raises a sticky error.
// Optional feature macro: BITSTREAM_SCHED_STATS_EN enables the saturating
// completed-load counter on boot_count_o; without it boot_count_o is 0.
module bitstream_sched #(
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int SLOT_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_i,
    input  logic              boot_req_i,
    input  logic [SLOT_W-1:0] boot_slot_i,
    output logic              flash_start_o,
    output logic [SLOT_W-1:0] flash_slot_o,
    input  logic              flash_busy_i,
    input  logic [31:0]       flash_data_i,
    input  logic              flash_valid_i,
    input  logic [31:0]       rx_data_i,
    input  logic              rx_valid_i,
    input  logic              cfg_busy_i,
    output logic [31:0]       cfg_data_o,
    output logic              cfg_valid_o,
    output logic              busy_o,
    output logic              error_o,
    output logic [7:0]        boot_count_o
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD,
        DRAIN,
        RX
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              boot_req_q;
    logic              req_edge;
    logic              pending;
    logic              pending_clr;
    logic [SLOT_W-1:0] pending_slot;
    logic              start_go;
    logic              seen_busy;
    logic [WD_W-1:0]   watchdog;
    logic              wd_expire;
    logic              timeout;
    logic              take_flash;
    logic              take_rx;

    assign req_edge   = boot_req_i & ~boot_req_q;
    assign wd_expire  = (watchdog == WD_LAST) & ~flash_valid_i;
    assign take_flash = (state == LOAD) & flash_valid_i;
    assign take_rx    = (state == RX) & rx_valid_i;

    assign flash_start_o = (state == START);
    assign busy_o        = (state == START) | (state == LOAD) | (state == DRAIN);

    // Next-state decode; mode_i is only honoured from IDLE and RX so a flash load
    // always runs to completion or timeout once started.
    always_comb begin
        state_nxt   = state;
        pending_clr = 1'b0;
        start_go    = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                if (mode_i) begin
                    state_nxt   = RX;
                    pending_clr = 1'b1;
                end else if (pending && !cfg_busy_i) begin
                    state_nxt   = START;
                    pending_clr = 1'b1;
                    start_go    = 1'b1;
                end
            end
            START: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                if (seen_busy && !flash_busy_i) begin
                    state_nxt = DRAIN;
                end else if (wd_expire) begin
                    state_nxt = IDLE;
                    timeout   = 1'b1;
                end
            end
            DRAIN: begin
                if (!cfg_busy_i) begin
                    state_nxt = IDLE;
                end
            end
            RX: begin
                // Requests arriving while the receiver owns the stream are dropped.
                pending_clr = 1'b1;
                if (!mode_i && !cfg_busy_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture; a fresh edge beats a same-cycle clear. Reset leaves a
    // cold-boot request for slot 0 pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_req_q   <= 1'b0;
            pending      <= 1'b1;
            pending_slot <= '0;
        end else begin
            boot_req_q <= boot_req_i;
            if (req_edge) begin
                pending      <= 1'b1;
                pending_slot <= boot_slot_i;
            end else if (pending_clr) begin
                pending <= 1'b0;
            end
        end
    end

    // Slot handed to the flash controller, latched as START is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_slot_o <= '0;
        end else if (start_go) begin
            flash_slot_o <= pending_slot;
        end
    end

    // Load tracking: busy-seen flag and wordless-cycle watchdog, armed in START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_busy <= 1'b0;
            watchdog  <= '0;
        end else if (state == START) begin
            seen_busy <= 1'b0;
            watchdog  <= '0;
        end else if (state == LOAD) begin
            if (flash_busy_i) begin
                seen_busy <= 1'b1;
            end
            if (flash_valid_i) begin
                watchdog <= '0;
            end else begin
                watchdog <= watchdog + WD_W'(1);
            end
        end
    end

    // Sticky watchdog error, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_o <= 1'b0;
        end else if (timeout) begin
            error_o <= 1'b1;
        end
    end

    // Output word register: one-cycle latency, data holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_valid_o <= 1'b0;
            cfg_data_o  <= '0;
        end else begin
            cfg_valid_o <= take_flash | take_rx;
            if (take_flash) begin
                cfg_data_o <= flash_data_i;
            end else if (take_rx) begin
                cfg_data_o <= rx_data_i;
            end
        end
    end

`ifdef BITSTREAM_SCHED_STATS_EN
    logic [7:0] boot_count;
    logic       load_done;

    assign load_done    = (state == DRAIN) & ~cfg_busy_i;
    assign boot_count_o = boot_count;

    // Completed flash loads, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_count <= 8'd0;
        end else if (load_done && boot_count != 8'hFF) begin
            boot_count <= boot_count + 8'd1;
        end
    end
`else
    assign boot_count_o = 8'd0;
`endif

endmodule
